// File: rtl/tpsram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tpsram_fifo_ctrl
//
// Single-clock FIFO controller that drives a two-port SRAM macro wrapper.
// Write port A and read port B use active-low enables. The macro's read
// latency is hidden behind a small prefetch output buffer. Push and pop are
// valid/ready streams.
//
// Optional feature macro: TPSRAM_OUT_PIPE_EN
//   undefined : RD_LAT=1, PF_DEPTH=3, Q captured directly into the buffer.
//   defined   : RD_LAT=2, PF_DEPTH=4, Q registered once more before capture.
//
// Ports:
//   Clk, Rst        clock (rising edge), synchronous active-high reset
//   wr_vld/wr_rdy   push handshake (wr_rdy registered), wr_data push data
//   rd_vld/rd_rdy   pop handshake (rd_vld registered), rd_data head entry
//   fifo_cnt        registered total occupancy (SRAM + in-flight + buffer)
//   AddrA/Din       SRAM write address/data, held between writes
//   CEAB/WEAB       SRAM write chip/write enable, active low
//   AddrB           SRAM read address, held between reads
//   CEBB/REBB       SRAM read chip/read enable, active low
//   Q               SRAM read data
// ---------------------------------------------------------------------------
module tpsram_fifo_ctrl #(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 75,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]  fifo_cnt,
    output logic [ADDR_WIDTH-1:0] AddrA,
    output logic [DATA_WIDTH-1:0] Din,
    output logic                  CEAB,
    output logic                  WEAB,
    output logic [ADDR_WIDTH-1:0] AddrB,
    output logic                  CEBB,
    output logic                  REBB,
    input  logic [DATA_WIDTH-1:0] Q
);

`ifdef TPSRAM_OUT_PIPE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int PF_DEPTH = RD_LAT + 2;
    localparam int PF_PW    = $clog2(PF_DEPTH);
    localparam int PF_CW    = $clog2(PF_DEPTH + 1);
    localparam logic [PF_CW:0]      PF_LIMIT = (PF_CW + 1)'(PF_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q, addra_q, addrb_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                  wr_rdy_q, rd_vld_q;
    logic [RD_LAT-1:0]     tag_q, tag_d;
    logic [DATA_WIDTH-1:0] obuf_q [PF_DEPTH];
    logic [PF_PW-1:0]      head_q, tail_q;
    logic [PF_CW-1:0]      obuf_cnt_q, obuf_cnt_d;
    logic [PF_CW-1:0]      inflight;
    logic [PF_CW:0]        pf_occ;
    logic [CNT_WIDTH-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  wr_fire, rd_fire, rd_issue, cap;

    function automatic logic [PF_CW-1:0] tag_count(input logic [RD_LAT-1:0] t);
        tag_count = '0;
        for (int i = 0; i < RD_LAT; i++) tag_count = tag_count + PF_CW'(t[i]);
    endfunction

    // Circular pointer for a buffer whose depth need not be a power of two.
    function automatic logic [PF_PW-1:0] pf_next(input logic [PF_PW-1:0] p);
        pf_next = (p == PF_PW'(PF_DEPTH - 1)) ? '0 : p + PF_PW'(1);
    endfunction

    // Enables are gated by Rst so nothing reaches the macro in a reset cycle.
    assign wr_fire  = wr_vld & wr_rdy_q & ~Rst;
    assign rd_fire  = rd_vld_q & rd_rdy;
    assign inflight = tag_count(tag_q);
    assign pf_occ   = (PF_CW + 1)'(obuf_cnt_q) + (PF_CW + 1)'(inflight);
    // Prefetch is driven purely by occupancy; rd_rdy stays out of this path.
    assign rd_issue = ~Rst & (mem_cnt_q != '0) & (pf_occ < PF_LIMIT);
    assign cap      = tag_q[RD_LAT-1];

`ifdef TPSRAM_OUT_PIPE_EN
    logic [DATA_WIDTH-1:0] q_pipe_q;

    // Pure data stage; its content is only used when the matching tag emerges.
    always_ff @(posedge Clk) begin
        q_pipe_q <= Q;
    end

    assign tag_d    = {tag_q[0], rd_issue};
    assign cap_data = q_pipe_q;
`else
    assign tag_d    = rd_issue;
    assign cap_data = Q;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mem_cnt_d  = mem_cnt_q;
        obuf_cnt_d = obuf_cnt_q;
        case ({wr_fire, rd_issue})
            2'b10:   mem_cnt_d = mem_cnt_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (ADDR_WIDTH + 1)'(1);
            default: ;
        endcase
        case ({cap, rd_fire})
            2'b10:   obuf_cnt_d = obuf_cnt_q + PF_CW'(1);
            2'b01:   obuf_cnt_d = obuf_cnt_q - PF_CW'(1);
            default: ;
        endcase
        fifo_cnt_d = CNT_WIDTH'(mem_cnt_d) + CNT_WIDTH'(tag_count(tag_d))
                   + CNT_WIDTH'(obuf_cnt_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            addra_q    <= '0;
            addrb_q    <= '0;
            din_q      <= '0;
            mem_cnt_q  <= '0;
            wr_rdy_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            tag_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            obuf_cnt_q <= '0;
            fifo_cnt_q <= '0;
            // NOTE: the buffer is a few flops, cleared so rd_data reads 0 out of reset; the SRAM itself is never cleared.
            for (int i = 0; i < PF_DEPTH; i++) obuf_q[i] <= '0;
        end else begin
            if (wr_fire) begin
                wptr_q  <= wptr_q + ADDR_WIDTH'(1);
                addra_q <= wptr_q;
                din_q   <= wr_data;
            end
            if (rd_issue) begin
                rptr_q  <= rptr_q + ADDR_WIDTH'(1);
                addrb_q <= rptr_q;
            end
            mem_cnt_q <= mem_cnt_d;
            // Full is judged on the next count, so a read issued this cycle frees a slot at once.
            wr_rdy_q  <= (mem_cnt_d < MEM_FULL);
            tag_q     <= tag_d;
            if (cap) begin
                obuf_q[tail_q] <= cap_data;
                tail_q         <= pf_next(tail_q);
            end
            if (rd_fire) head_q <= pf_next(head_q);
            obuf_cnt_q <= obuf_cnt_d;
            rd_vld_q   <= (obuf_cnt_d != '0);
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign wr_rdy   = wr_rdy_q;
    assign rd_vld   = rd_vld_q;
    assign rd_data  = obuf_q[head_q];
    assign fifo_cnt = fifo_cnt_q;
    assign CEAB     = ~wr_fire;
    assign WEAB     = ~wr_fire;
    assign AddrA    = wr_fire ? wptr_q : addra_q;
    assign Din      = wr_fire ? wr_data : din_q;
    assign CEBB     = ~rd_issue;
    assign REBB     = ~rd_issue;
    assign AddrB    = rd_issue ? rptr_q : addrb_q;

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tpsram_fifo_ctrl
//
// Bench for tpsram_fifo_ctrl with a behavioural 1-cycle two-port SRAM.
// Accepted pushes go into an expected-data queue; a monitor pops and
// compares on every accepted pop and tracks the occupancy model.
// ---------------------------------------------------------------------------
module tb_tpsram_fifo_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 75;
    localparam int CW    = 12;
    localparam int DEPTH = 1024;
`ifdef TPSRAM_OUT_PIPE_EN
    localparam int EXP_LAT = 4;
    localparam int PF      = 4;
`else
    localparam int EXP_LAT = 3;
    localparam int PF      = 3;
`endif

    logic          Clk     = 1'b0;
    logic          Rst     = 1'b1;
    logic          wr_vld  = 1'b0;
    logic          rd_rdy  = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_rdy, rd_vld, CEAB, WEAB, CEBB, REBB;
    logic [DW-1:0] rd_data, Din;
    logic [DW-1:0] Q;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] AddrA, AddrB;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            tests     = 0;
    int            fails     = 0;
    int            model_cnt = 0;
    bit            mon_en    = 1'b0;

    always #5 Clk = ~Clk;

    tpsram_fifo_ctrl #(
        .MEM_DEPTH (DEPTH),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_vld  (wr_vld),
        .wr_rdy  (wr_rdy),
        .wr_data (wr_data),
        .rd_vld  (rd_vld),
        .rd_rdy  (rd_rdy),
        .rd_data (rd_data),
        .fifo_cnt(fifo_cnt),
        .AddrA   (AddrA),
        .Din     (Din),
        .CEAB    (CEAB),
        .WEAB    (WEAB),
        .AddrB   (AddrB),
        .CEBB    (CEBB),
        .REBB    (REBB),
        .Q       (Q)
    );

    // Behavioural SRAM macro, one cycle read latency.
    always @(posedge Clk) begin
        if (!CEAB && !WEAB) mem[AddrA] <= Din;
        if (!CEBB && !REBB) Q <= mem[AddrB];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (!CEAB && !CEBB) begin
                tests++;
                if (AddrA == AddrB) begin
                    fails++;
                    $display("FAIL port_collision: AddrA=0x%0h AddrB=0x%0h", AddrA, AddrB);
                end
            end
            check("fifo_cnt_model", fifo_cnt, model_cnt);
            if (Rst) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                if (wr_vld && wr_rdy) begin
                    exp_q.push_back(wr_data);
                    model_cnt++;
                end
                if (rd_vld && rd_rdy) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL pop_unexpected: got 0x%0h expected none", rd_data);
                    end else begin
                        check("rd_data_order", rd_data, exp_q.pop_front());
                    end
                    model_cnt--;
                end
            end
        end
    end

    task automatic drain(input int budget);
        int c;
        c      = 0;
        wr_vld = 1'b0;
        rd_rdy = 1'b1;
        @(negedge Clk);
        while ((fifo_cnt != 0 || rd_vld) && c < budget) begin
            tick();
            @(negedge Clk);
            c++;
        end
        check("drain_fifo_cnt", fifo_cnt, 0);
        check("drain_sb_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, pops, first, last, last_acc, wa, wb, maxc, stall, rise;

        // ---- 1: reset state and first push ----
        Rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge Clk);
        check("rst_wr_rdy", wr_rdy, 0);
        check("rst_rd_vld", rd_vld, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_enables", {CEAB, WEAB, CEBB, REBB}, 4'hF);
        check("rst_addr", {AddrA, AddrB}, 0);
        check("rst_din", Din, 0);
        tick();
        Rst = 1'b0;
        tick();
        wr_vld  = 1'b1;
        wr_data = DW'(1);
        rd_rdy  = 1'b1;
        @(negedge Clk);
        check("t1_wr_rdy_after_rst", wr_rdy, 1);
        check("t1_write_en", {CEAB, WEAB}, 2'b00);
        check("t1_addra", AddrA, 0);
        check("t1_din", Din, 1);
        check("t1_no_read_c0", CEBB, 1);
        tick();
        wr_vld = 1'b0;
        @(negedge Clk);
        check("t1_read_en", {CEBB, REBB}, 2'b00);
        check("t1_addrb", AddrB, 0);
        check("t1_write_idle", {CEAB, WEAB}, 2'b11);
        lat = 1;
        while (!rd_vld && lat < 10) begin
            tick();
            lat++;
            @(negedge Clk);
        end
        check("t1_latency", lat, EXP_LAT);
        check("t1_rd_data", rd_data, 1);
        tick();
        @(negedge Clk);
        check("t1_cnt_after_pop", fifo_cnt, 0);
        check("t1_rd_vld_after_pop", rd_vld, 0);
        tick();

        // ---- 2: streaming 0..4095 ----
        acc = 0; pops = 0; first = -1; last = -1; last_acc = -1; wa = 0; wb = 0; maxc = 0;
        rd_rdy = 1'b1;
        for (int c = 0; c < 4096 + 20; c++) begin
            wr_vld  = (acc < 4096);
            wr_data = DW'(acc);
            @(negedge Clk);
            if (wr_vld && wr_rdy) begin
                acc++;
                last_acc = c;
            end
            if (rd_vld && rd_rdy) begin
                pops++;
                if (first < 0) first = c;
                last = c;
            end
            if (!CEAB && AddrA == AW'(DEPTH - 1)) wa++;
            if (!CEBB && AddrB == AW'(DEPTH - 1)) wb++;
            if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
            tick();
        end
        check("t2_accepted", acc, 4096);
        check("t2_no_write_stall", last_acc, 4095);
        check("t2_pops", pops, 4096);
        check("t2_no_bubbles", last - first + 1, 4096);
        check("t2_wrap_addra", wa, 4);
        check("t2_wrap_addrb", wb, 4);
        check("t2_max_cnt_le4", (maxc <= 4), 1);
        drain(50);

        // ---- 3: fill until stall ----
        rd_rdy = 1'b0;
        acc = 0; stall = 0;
        for (int c = 0; c < 1300 && stall < 8; c++) begin
            wr_vld  = 1'b1;
            wr_data = DW'(32'h1_0000 + acc);
            @(negedge Clk);
            if (wr_rdy) begin
                acc++;
                stall = 0;
            end else begin
                stall++;
            end
            tick();
        end
        @(negedge Clk);
        check("t3_accepted", acc, DEPTH + PF);
        check("t3_wr_rdy_low", wr_rdy, 0);
        check("t3_fifo_cnt_full", fifo_cnt, DEPTH + PF);
        tick();

        // ---- 4: single pop from full ----
        wr_vld = 1'b0;
        rd_rdy = 1'b1;
        @(negedge Clk);
        check("t4_rd_vld_pre", rd_vld, 1);
        tick();
        rd_rdy  = 1'b0;
        wr_vld  = 1'b1;
        wr_data = DW'(32'h2_0000);
        rise = 0; acc = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            if (wr_rdy && rise == 0) rise = c;
            if (wr_rdy) acc++;
            tick();
        end
        @(negedge Clk);
        check("t4_rise_within_2", (rise >= 1 && rise <= 2), 1);
        check("t4_one_push", acc, 1);
        check("t4_wr_rdy_low_again", wr_rdy, 0);
        check("t4_fifo_cnt_full", fifo_cnt, DEPTH + PF);
        tick();
        drain(1300);

        // ---- 5: random traffic ----
        for (int c = 0; c < 20000; c++) begin
            wr_vld  = 1'($urandom_range(0, 1));
            rd_rdy  = 1'($urandom_range(0, 1));
            wr_data = DW'({$urandom, $urandom, $urandom});
            tick();
        end
        drain(1300);

        // ---- 6: reset mid-operation ----
        rd_rdy = 1'b0;
        wr_vld = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wr_data = DW'(32'h3_0000 + c);
            tick();
        end
        @(negedge Clk);
        check("t6_rd_vld_pre", rd_vld, 1);
        tick();
        Rst    = 1'b1;
        rd_rdy = 1'b1;
        tick();
        Rst    = 1'b0;
        wr_vld = 1'b0;
        @(negedge Clk);
        check("t6_rd_vld", rd_vld, 0);
        check("t6_fifo_cnt", fifo_cnt, 0);
        check("t6_enables", {CEAB, WEAB, CEBB, REBB}, 4'hF);
        check("t6_rd_data", rd_data, 0);
        tick();
        wr_vld  = 1'b1;
        wr_data = DW'(32'hA);
        @(negedge Clk);
        check("t6_write_en", {CEAB, WEAB}, 2'b00);
        check("t6_addra_restart", AddrA, 0);
        tick();
        wr_vld = 1'b0;
        lat = 1;
        @(negedge Clk);
        check("t6_addrb_restart", {CEBB, AddrB}, 0);
        while (!rd_vld && lat < 10) begin
            tick();
            lat++;
            @(negedge Clk);
        end
        check("t6_latency", lat, EXP_LAT);
        check("t6_rd_data_a", rd_data, 32'hA);
        tick();
        @(negedge Clk);
        check("t6_no_stale", rd_vld, 0);
        check("t6_cnt_zero", fifo_cnt, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
